// File: rtl/spram_mem_ctrl.sv
// Load/store front-end for the 16K x 32 SPRAM: registers one B/H/W request,
// drives address/data/nibble strobes and returns extended load data.
module spram_mem_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [13:0] ram_addr,
  output logic [31:0] ram_data_in,
  output logic [7:0]  ram_wren,
  input  logic [31:0] ram_data_out
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RDWAIT = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

  logic [1:0]  state;
  logic        we_q;
  logic        err_q;
  logic [2:0]  f3_q;
  logic [15:0] addr_q;
  logic [31:0] wdata_q;

  logic        f3_bad;
  logic        misal;
  logic        req_err;
  logic [7:0]  wmask;
  logic [7:0]  bsel;
  logic [15:0] hsel;
  logic [31:0] load_val;

  // Unsigned widths are loads only; anything outside the five codes is illegal.
  always_comb begin
    f3_bad = 1'b0;
    misal  = 1'b0;
    case (req_funct3)
      F_B:  f3_bad = 1'b0;
      F_H:  misal  = req_addr[0];
      F_W:  misal  = |req_addr[1:0];
      F_BU: f3_bad = req_we;
      F_HU: begin
        f3_bad = req_we;
        misal  = req_addr[0];
      end
      default: f3_bad = 1'b1;
    endcase
    req_err = (|req_addr[31:16]) | f3_bad | misal;
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == DONE) & ~reset;
  assign ram_addr   = addr_q[15:2];

  always_comb begin
    wmask       = 8'hFF;
    ram_data_in = wdata_q;
    case (f3_q[1:0])
      2'b00: begin
        wmask       = 8'h03 << {addr_q[1:0], 1'b0};
        ram_data_in = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        wmask       = 8'h0F << {addr_q[1], 2'b00};
        ram_data_in = {2{wdata_q[15:0]}};
      end
      default: begin
        wmask       = 8'hFF;
        ram_data_in = wdata_q;
      end
    endcase
  end

  // Reset gates the strobe combinationally so a write in flight is dropped.
  assign ram_wren = (state == ACCESS && we_q && !err_q && !reset) ? wmask : 8'h00;

  always_comb begin
    bsel = ram_data_out[{addr_q[1:0], 3'b000} +: 8];
    hsel = ram_data_out[{addr_q[1], 4'b0000} +: 16];
    case (f3_q)
      F_B:     load_val = {{24{bsel[7]}}, bsel};
      F_H:     load_val = {{16{hsel[15]}}, hsel};
      F_BU:    load_val = {24'h0, bsel};
      F_HU:    load_val = {16'h0, hsel};
      default: load_val = ram_data_out;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      f3_q       <= 3'b000;
      addr_q     <= 16'h0;
      wdata_q    <= 32'h0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            addr_q  <= req_addr[15:0];
            wdata_q <= req_wdata;
            err_q   <= req_err;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          if (err_q || we_q) begin
            resp_err   <= err_q;
            resp_rdata <= 32'h0;
            state      <= DONE;
          end else begin
            state <= RDWAIT;
          end
        end
        RDWAIT: begin
          resp_err   <= 1'b0;
          resp_rdata <= load_val;
          state      <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spram_mem_ctrl.sv
// Directed + random bench for spram_mem_ctrl against a byte-level memory model.
module tb_spram_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        req_ready;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [13:0] ram_addr;
  logic [31:0] ram_data_in;
  logic [7:0]  ram_wren;
  logic [31:0] ram_data_out;

  int ncomp = 0;
  int nfail = 0;

  bit [31:0] spram   [0:16383];
  bit [7:0]  ref_mem [0:65535];

  spram_mem_ctrl dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .ram_addr(ram_addr), .ram_data_in(ram_data_in), .ram_wren(ram_wren),
    .ram_data_out(ram_data_out)
  );

  always #5 clk = ~clk;

  // SPRAM wrapper: nibble writes, registered read
  always @(posedge clk) begin
    for (int i = 0; i < 8; i++)
      if (ram_wren[i]) spram[ram_addr][4*i +: 4] <= ram_data_in[4*i +: 4];
    ram_data_out <= spram[ram_addr];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: byte-addressed memory, width/sign from funct3, updates on stores.
  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, output logic err, output logic [31:0] rd,
                                output logic [7:0] wm, output logic [31:0] din);
    int size = 1;
    bit sgn = 1'b0;
    bit legal = 1'b1;
    longint v = 0;
    case (f3)
      3'd0: begin size = 1; sgn = 1'b1; end
      3'd1: begin size = 2; sgn = 1'b1; end
      3'd2: begin size = 4; end
      3'd4: begin size = 1; legal = !we; end
      3'd5: begin size = 2; legal = !we; end
      default: legal = 1'b0;
    endcase
    err = !legal || (a > 32'h0000_FFFF) || ((a % 32'(size)) != 0);
    rd = 32'h0; wm = 8'h0; din = 32'h0;
    if (!err && we) begin
      wm = 8'(((32'd1 << (2*size)) - 1) << (2*(a % 4)));
      din = (size == 1) ? 32'(wd[7:0]) * 32'h0101_0101 :
            (size == 2) ? 32'(wd[15:0]) * 32'h0001_0001 : wd;
      for (int k = 0; k < size; k++) ref_mem[a + 32'(k)] = wd[8*k +: 8];
    end
    if (!err && !we) begin
      for (int k = 0; k < size; k++) v = v | (longint'(ref_mem[a + 32'(k)]) << (8*k));
      if (sgn && size < 4 && v[8*size-1]) v = v - (longint'(1) << (8*size));
      rd = v[31:0];
    end
  endfunction

  // Called at a negedge with the block idle; returns at a negedge with it idle again.
  task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    logic eerr;
    logic [31:0] erd, edin;
    logic [7:0] ewm;
    int n;
    model(we, f3, a, wd, eerr, erd, ewm, edin);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    chk("accept_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("ram_addr", 32'(ram_addr), 32'(a[15:2]));
    chk("ram_wren", 32'(ram_wren), 32'(ewm));
    if (ewm != 8'h0) chk("ram_data_in", ram_data_in, edin);
    n = 1;
    while (!resp_valid && n < 8) begin
      @(negedge clk); n++;
      chk("wren_quiet", 32'(ram_wren), 32'd0);
    end
    chk("resp_valid", 32'(resp_valid), 32'd1);
    chk("latency", 32'(n), (we || eerr) ? 32'd2 : 32'd3);
    chk("resp_err", 32'(resp_err), 32'(eerr));
    chk("resp_rdata", resp_rdata, erd);
    @(negedge clk);
    chk("resp_pulse", 32'(resp_valid), 32'd0);
  endtask

  task automatic b2b(input logic we, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input int gap);
    int acc = 0;
    int resps = 0;
    int prev = -1;
    logic eerr;
    logic [31:0] erd, edin;
    logic [7:0] ewm;
    model(we, f3, a, wd, eerr, erd, ewm, edin);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    for (int i = 0; i < 24; i++) begin
      if (resp_valid) resps++;
      if (i == 23) req_valid = 1'b0;
      else if (req_ready) begin
        acc++;
        if (prev >= 0) chk("b2b_spacing", 32'(i - prev), 32'(gap));
        prev = i;
      end
      @(negedge clk);
    end
    repeat (6) begin
      if (resp_valid) resps++;
      @(negedge clk);
    end
    chk("b2b_accepts", 32'(acc), 32'(22 / gap + 1));
    chk("b2b_resps", 32'(resps), 32'(acc));
  endtask

  initial begin
    logic [2:0] legal_f3 [5];
    logic [31:0] a;
    legal_f3[0] = 3'd0; legal_f3[1] = 3'd1; legal_f3[2] = 3'd2;
    legal_f3[3] = 3'd4; legal_f3[4] = 3'd5;

    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_ram_data_in", ram_data_in, 32'd0);
    chk("rst_ram_wren", 32'(ram_wren), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    xact(1'b1, 3'd2, 32'h100, 32'hDEADBEEF);
    xact(1'b0, 3'd2, 32'h100, 32'h0);
    xact(1'b1, 3'd0, 32'h103, 32'h0000_0080);
    xact(1'b0, 3'd0, 32'h103, 32'h0);
    xact(1'b0, 3'd4, 32'h103, 32'h0);
    xact(1'b0, 3'd2, 32'h100, 32'h0);
    xact(1'b1, 3'd1, 32'h102, 32'h0000_1234);
    xact(1'b0, 3'd5, 32'h102, 32'h0);
    xact(1'b1, 3'd1, 32'h102, 32'h0000_8001);
    xact(1'b0, 3'd1, 32'h102, 32'h0);
    xact(1'b0, 3'd5, 32'h102, 32'h0);

    xact(1'b0, 3'd2, 32'h102, 32'h0);
    xact(1'b0, 3'd1, 32'h101, 32'h0);
    xact(1'b1, 3'd2, 32'h0001_0000, 32'hFFFF_FFFF);
    xact(1'b0, 3'd3, 32'h100, 32'h0);
    xact(1'b1, 3'd4, 32'h100, 32'h0000_00AA);
    xact(1'b1, 3'd1, 32'h101, 32'h0000_BBBB);
    xact(1'b0, 3'd2, 32'h100, 32'h0);

    // reset during the ACCESS cycle of a store
    xact(1'b1, 3'd2, 32'h200, 32'h0BAD_F00D);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h200; req_wdata = 32'h5555_5555;
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_access_wren", 32'(ram_wren), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_after_ready", 32'(req_ready), 32'd1);
    chk("rst_after_resp", 32'(resp_valid), 32'd0);
    @(negedge clk);
    chk("rst_no_resp", 32'(resp_valid), 32'd0);
    xact(1'b0, 3'd2, 32'h200, 32'h0);

    b2b(1'b1, 3'd2, 32'h300, 32'hCAFE_F00D, 3);
    b2b(1'b0, 3'd2, 32'h300, 32'h0, 4);
    xact(1'b0, 3'd2, 32'h300, 32'h0);

    for (int t = 0; t < 80; t++) begin
      logic [2:0] f3;
      if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(0, 7));
      else f3 = legal_f3[$urandom_range(0, 4)];
      if ($urandom_range(0, 9) == 0) a = $urandom();
      else a = 32'h400 + 32'($urandom_range(0, 31));
      xact(1'($urandom_range(0, 1)), f3, a, $urandom());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
